// File: rtl/pgm_loader.sv
// pgm_loader: streams a raw BIN or Intel HEX download into 16-bit program memory while holding the CPU in reset.
// Optional feature: define PGM_LOADER_CHECKSUM_EN to verify HEX record checksums.
module pgm_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_lane,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [3:0] {
    WAIT_COLON, CNT_H, CNT_L, ADR3, ADR2, ADR1, ADR0,
    TYP_H, TYP_L, DAT_H, DAT_L, SUM_H, SUM_L
  } state_t;

  state_t      r_state;
  logic        r_dl_d;
  logic        r_hex;
  logic        r_eof;
  logic [1:0]  r_hold_cnt;
  logic [3:0]  r_nib;
  logic [7:0]  r_cnt;
  logic [7:0]  r_typ;
  logic [15:0] r_addr;

  // Returns {valid, value} for an ASCII hex digit.
  function automatic logic [4:0] hex_digit(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

  logic       w_dl_rise;
  logic       w_dl_fall;
  logic       w_bin_wr;
  logic       w_hex_wr;
  logic [4:0] w_dig;
  logic [7:0] w_byte;
  logic [7:0] w_cnt_dec;

  assign w_dl_rise = ioctl_download & ~r_dl_d;
  assign w_dl_fall = ~ioctl_download & r_dl_d;
  assign w_bin_wr  = ioctl_wr & ioctl_download & ~w_dl_rise & ~r_hex;
  assign w_hex_wr  = ioctl_wr & ioctl_download & ~w_dl_rise & r_hex & ~r_eof;
  assign w_dig     = hex_digit(ioctl_dout);
  assign w_byte    = {r_nib, w_dig[3:0]};
  assign w_cnt_dec = r_cnt - 8'd1;

`ifdef PGM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  logic       w_low_nib;
  assign w_sum_next = r_sum + w_byte;
  assign w_low_nib  = (r_state == CNT_L) || (r_state == ADR2) || (r_state == ADR0) ||
                      (r_state == TYP_L) || (r_state == DAT_L) || (r_state == SUM_L);
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= WAIT_COLON;
      r_dl_d     <= 1'b0;
      r_hex      <= 1'b0;
      r_eof      <= 1'b0;
      r_hold_cnt <= 2'd0;
      r_nib      <= 4'd0;
      r_cnt      <= 8'd0;
      r_typ      <= 8'd0;
      r_addr     <= 16'd0;
`ifdef PGM_LOADER_CHECKSUM_EN
      r_sum      <= 8'd0;
`endif
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_lane   <= 1'b0;
      mem_wdata  <= 8'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      r_dl_d <= ioctl_download;
      mem_we <= 1'b0;

      // Hold stretches two cycles past the end of the download.
      if (ioctl_download) begin
        cpu_hold   <= 1'b1;
        r_hold_cnt <= 2'd2;
      end else if (r_hold_cnt != 2'd0) begin
        cpu_hold   <= 1'b1;
        r_hold_cnt <= r_hold_cnt - 2'd1;
      end else begin
        cpu_hold   <= 1'b0;
      end

      if (w_dl_rise) begin
        r_hex     <= |ioctl_index;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        r_eof     <= 1'b0;
        r_state   <= WAIT_COLON;
      end else if (w_dl_fall) begin
        load_done <= 1'b1;
        if (r_hex && !r_eof) load_err <= 1'b1;
        r_state   <= WAIT_COLON;
      end else if (w_bin_wr) begin
        mem_we    <= 1'b1;
        mem_addr  <= ioctl_addr[ADDR_W-1:1];
        mem_lane  <= ioctl_addr[0];
        mem_wdata <= ioctl_dout;
      end else if (w_hex_wr) begin
        if (r_state == WAIT_COLON) begin
          if (ioctl_dout == 8'h3A) begin
            r_state <= CNT_H;
`ifdef PGM_LOADER_CHECKSUM_EN
            r_sum   <= 8'd0;
`endif
          end
        end else if (!w_dig[4]) begin
          load_err <= 1'b1;
          r_state  <= WAIT_COLON;
        end else begin
`ifdef PGM_LOADER_CHECKSUM_EN
          if (w_low_nib) r_sum <= w_sum_next;
`endif
          case (r_state)
            CNT_H: begin r_nib <= w_dig[3:0]; r_state <= CNT_L; end
            CNT_L: begin r_cnt <= w_byte;     r_state <= ADR3;  end
            ADR3:  begin r_nib <= w_dig[3:0]; r_state <= ADR2;  end
            ADR2:  begin r_addr[15:8] <= w_byte; r_state <= ADR1; end
            ADR1:  begin r_nib <= w_dig[3:0]; r_state <= ADR0;  end
            ADR0:  begin r_addr[7:0] <= w_byte;  r_state <= TYP_H; end
            TYP_H: begin r_nib <= w_dig[3:0]; r_state <= TYP_L; end
            TYP_L: begin
              r_typ   <= w_byte;
              r_state <= (r_cnt != 8'd0) ? DAT_H : SUM_H;
            end
            DAT_H: begin r_nib <= w_dig[3:0]; r_state <= DAT_L; end
            DAT_L: begin
              if (r_typ == 8'h00) begin
                mem_we    <= 1'b1;
                mem_addr  <= r_addr[ADDR_W-1:1];
                mem_lane  <= r_addr[0];
                mem_wdata <= w_byte;
              end
              r_addr  <= r_addr + 16'd1;
              r_cnt   <= w_cnt_dec;
              r_state <= (w_cnt_dec != 8'd0) ? DAT_H : SUM_H;
            end
            SUM_H: begin r_nib <= w_dig[3:0]; r_state <= SUM_L; end
            SUM_L: begin
`ifdef PGM_LOADER_CHECKSUM_EN
              if (w_sum_next != 8'd0) load_err <= 1'b1;
`endif
              if (r_typ == 8'h01) r_eof <= 1'b1;
              r_state <= WAIT_COLON;
            end
            default: r_state <= WAIT_COLON;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pgm_loader.sv
// Bench for pgm_loader: directed table vectors, reset/timing sequences and random BIN/HEX files vs a record-level model.
`timescale 1ns/1ps
module tb_pgm_loader;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dl  = 1'b0;
  logic          wr  = 1'b0;
  logic [7:0]    idx = 8'd0;
  logic [7:0]    dout = 8'd0;
  logic [AW-1:0] addr = '0;
  logic          mem_we;
  logic [AW-2:0] mem_addr;
  logic          mem_lane;
  logic [7:0]    mem_wdata;
  logic          cpu_hold, load_done, load_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [AW-2:0] a;
    logic          l;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    string name;
    string file;
    int    nw;
    wr_t   w0;
    wr_t   w1;
    logic  err;
  } vec_t;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic exp_err;

  pgm_loader #(.ADDR_W(AW)) dut (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(idx),
    .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_lane(mem_lane), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mem_we) got_q.push_back('{mem_addr, mem_lane, mem_wdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int a, input int gap);
    @(negedge clk);
    dout = b;
    addr = a[AW-1:0];
    wr   = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit rnd_gap);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], i, rnd_gap ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic start_dl(input logic [7:0] index);
    @(negedge clk);
    idx = index;
    dl  = 1'b1;
    got_q.delete();
    @(negedge clk);
    check("start hold", cpu_hold, 1);
    check("start done cleared", load_done, 0);
    check("start err cleared", load_err, 0);
  endtask

  task automatic end_dl();
    @(negedge clk);
    dl = 1'b0;
    @(negedge clk);
    check("done after fall", load_done, 1);
    @(negedge clk);
    check("hold 2 cycles after fall", cpu_hold, 1);
    @(negedge clk);
    check("hold low 3 cycles after fall", cpu_hold, 0);
    @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, " nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s write%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // 0 = byte decoded, 1 = bad character consumed, 2 = file ended.
  function automatic int get_byte(input string s, inout int pos, output int val);
    int h, l;
    val = 0;
    if (pos >= s.len()) return 2;
    h = hexv(s[pos]);
    pos++;
    if (h < 0) return 1;
    if (pos >= s.len()) return 2;
    l = hexv(s[pos]);
    pos++;
    if (l < 0) return 1;
    val = h * 16 + l;
    return 0;
  endfunction

  // Record-level reference: which bytes land in memory and whether the load is flagged bad.
  task automatic hex_model(input string s);
    int pos, st, cnt, ah, al, typ, d, cs, sum;
    logic [15:0] a;
    bit eof;
    exp_q.delete();
    exp_err = 1'b0;
    eof = 1'b0;
    pos = 0;
    while (pos < s.len() && !eof) begin
      if (s[pos] != 8'h3A) begin pos++; continue; end
      pos++;
      cnt = 0; ah = 0; al = 0; typ = 0;
      st = get_byte(s, pos, cnt);
      if (st == 0) st = get_byte(s, pos, ah);
      if (st == 0) st = get_byte(s, pos, al);
      if (st == 0) st = get_byte(s, pos, typ);
      a = 16'(ah * 256 + al);
      sum = cnt + ah + al + typ;
      for (int i = 0; st == 0 && i < cnt; i++) begin
        st = get_byte(s, pos, d);
        if (st == 0) begin
          sum += d;
          if (typ == 0) begin
            exp_q.push_back('{a[AW-1:1], a[0], 8'(d)});
            a = a + 16'd1;
          end
        end
      end
      if (st == 0) st = get_byte(s, pos, cs);
      if (st == 2) break;
      if (st == 1) begin exp_err = 1'b1; continue; end
      sum += cs;
`ifdef PGM_LOADER_CHECKSUM_EN
      if (sum % 256 != 0) exp_err = 1'b1;
`endif
      if (typ == 1) eof = 1'b1;
    end
    if (!eof) exp_err = 1'b1;
  endtask

  function automatic string hx(input int v, input bit lc);
    return lc ? $sformatf("%02x", v & 255) : $sformatf("%02X", v & 255);
  endfunction

  task automatic gen_hex(output string s);
    int nrec, typ, cnt, sum, cs, d, k, r;
    logic [15:0] a;
    bit lc;
    string rec;
    s = "";
    nrec = $urandom_range(1, 4);
    for (int n = 0; n < nrec; n++) begin
      r   = $urandom_range(0, 9);
      typ = (r == 7) ? 2 : (r == 8) ? 4 : 0;
      cnt = $urandom_range(0, 4);
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      lc  = 1'($urandom);
      rec = {":", hx(cnt, lc), hx(int'(a[15:8]), lc), hx(int'(a[7:0]), lc), hx(typ, lc)};
      sum = cnt + int'(a[15:8]) + int'(a[7:0]) + typ;
      for (int i = 0; i < cnt; i++) begin
        d = $urandom_range(0, 255);
        rec = {rec, hx(d, lc)};
        sum += d;
      end
      cs = (256 - sum % 256) % 256;
      if ($urandom_range(0, 7) == 0) cs = (cs + 1) % 256;
      rec = {rec, hx(cs, lc)};
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(1, rec.len() - 1);
        rec.putc(k, "G");
      end
      r = $urandom_range(0, 2);
      s = {s, rec, (r == 0) ? "\r\n" : (r == 1) ? " " : "\n"};
    end
    if ($urandom_range(0, 4) != 0)
      s = {s, ":00000001FF\r\n:01000000AA55\r\n"};
    else
      s = s.substr(0, $urandom_range(1, s.len() - 2));
  endtask

  vec_t tbl[4];
  string s;
  int na, nd;

  initial begin
    tbl[0] = '{"hex basic", ":0200100034127A\r\n:00000001FF", 2,
               '{14'd8, 1'b0, 8'h34}, '{14'd8, 1'b1, 8'h12},
`ifdef PGM_LOADER_CHECKSUM_EN
               1'b1};
`else
               1'b0};
`endif
    tbl[1] = '{"bad digit", ":02001G:0100000055AA\r\n:00000001FF", 1,
               '{14'd0, 1'b0, 8'h55}, '{14'd0, 1'b0, 8'h00}, 1'b1};
    tbl[2] = '{"checksum", ":0100000055AB\r\n:00000001FF", 1,
               '{14'd0, 1'b0, 8'h55}, '{14'd0, 1'b0, 8'h00},
`ifdef PGM_LOADER_CHECKSUM_EN
               1'b1};
`else
               1'b0};
`endif
    tbl[3] = '{"truncated", ":0400", 0,
               '{14'd0, 1'b0, 8'h00}, '{14'd0, 1'b0, 8'h00}, 1'b1};

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_lane", mem_lane, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst cpu_hold", cpu_hold, 1);
    check("rst load_done", load_done, 0);
    check("rst load_err", load_err, 0);
    repeat (2) @(negedge clk);
    check("rst hold while in reset", cpu_hold, 1);
    rst = 1'b0;
    @(negedge clk);
    check("hold released after reset", cpu_hold, 0);

    // BIN with strobe-to-write timing
    start_dl(8'd0);
    @(negedge clk);
    dout = 8'h11; addr = '0; wr = 1'b1;
    check("bin idle we", mem_we, 0);
    @(posedge clk); #1;
    check("bin w0 we", mem_we, 1);
    check("bin w0 addr", mem_addr, 0);
    check("bin w0 lane", mem_lane, 0);
    check("bin w0 data", mem_wdata, 8'h11);
    @(negedge clk);
    dout = 8'h22; addr = 15'd1; wr = 1'b1;
    @(posedge clk); #1;
    check("bin w1 we", mem_we, 1);
    check("bin w1 addr", mem_addr, 0);
    check("bin w1 lane", mem_lane, 1);
    check("bin w1 data", mem_wdata, 8'h22);
    @(negedge clk);
    wr = 1'b0;
    @(posedge clk); #1;
    check("bin we one cycle", mem_we, 0);
    end_dl();
    check("bin err", load_err, 0);
    send_byte(8'h33, 2, 0);
    send_byte(8'h3A, 3, 0);
    repeat (2) @(negedge clk);
    check("wr ignored while idle", got_q.size(), 2);

    // Directed HEX vectors
    foreach (tbl[i]) begin
      start_dl(8'd1);
      send_str(tbl[i].file, 1'b0);
      end_dl();
      check({tbl[i].name, " nwrites"}, got_q.size(), tbl[i].nw);
      if (tbl[i].nw > 0 && got_q.size() > 0) check({tbl[i].name, " write0"}, 32'(got_q[0]), 32'(tbl[i].w0));
      if (tbl[i].nw > 1 && got_q.size() > 1) check({tbl[i].name, " write1"}, 32'(got_q[1]), 32'(tbl[i].w1));
      check({tbl[i].name, " err"}, load_err, tbl[i].err);
    end

    // Random files against the reference model
    for (int it = 0; it < 24; it++) begin
      if (it % 3 == 2) begin
        exp_q.delete();
        start_dl(8'd0);
        na = $urandom_range(4, 12);
        for (int j = 0; j < na; j++) begin
          logic [AW-1:0] ra;
          ra = AW'($urandom);
          nd = $urandom_range(0, 255);
          exp_q.push_back('{ra[AW-1:1], ra[0], 8'(nd)});
          send_byte(8'(nd), int'(ra), $urandom_range(0, 2));
        end
        end_dl();
        cmp_writes($sformatf("rand bin %0d", it));
        check($sformatf("rand bin %0d err", it), load_err, 0);
      end else begin
        gen_hex(s);
        hex_model(s);
        start_dl(8'($urandom_range(1, 255)));
        send_str(s, 1'b1);
        end_dl();
        cmp_writes($sformatf("rand hex %0d", it));
        check($sformatf("rand hex %0d err", it), load_err, exp_err);
      end
    end

    // Reset while a data byte is being accepted
    start_dl(8'd1);
    send_str(":01000000", 1'b0);
    send_byte("5", 9, 0);
    @(negedge clk);
    dout = "5"; addr = 15'd10; wr = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst mem_we", mem_we, 0);
    check("midrst mem_addr", mem_addr, 0);
    check("midrst mem_lane", mem_lane, 0);
    check("midrst mem_wdata", mem_wdata, 0);
    check("midrst cpu_hold", cpu_hold, 1);
    check("midrst load_done", load_done, 0);
    check("midrst load_err", load_err, 0);
    @(posedge clk); #1;
    check("midrst no write", mem_we, 0);
    @(negedge clk);
    wr = 1'b0;
    dl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst hold released", cpu_hold, 0);
    check("midrst done stays low", load_done, 0);
    check("midrst writes", got_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
